// File: rtl/urna_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | urna_pkg: state encoding, digit width and candidate codes for Urna TX     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package urna_pkg;

  localparam int URNA_DIGIT_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_NEXT   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_CHECK  = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;
  localparam logic [2:0] ST_CLOSED = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_NEXT   = ST_NEXT,
    S_SETUP  = ST_SETUP,
    S_STROBE = ST_STROBE,
    S_GAP    = ST_GAP,
    S_CHECK  = ST_CHECK,
    S_FINISH = ST_FINISH,
    S_CLOSED = ST_CLOSED
  } state_t;

  localparam logic [15:0] CAND_0 = 16'h3494;
  localparam logic [15:0] CAND_1 = 16'h3485;
  localparam logic [15:0] CAND_2 = 16'h3472;
  localparam logic [15:0] CAND_3 = 16'h3504;

  function automatic logic is_candidate(input logic [15:0] ballot);
    return (ballot == CAND_0) || (ballot == CAND_1) ||
           (ballot == CAND_2) || (ballot == CAND_3);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/urna_pulse_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | urna_pulse_timer: loadable down-counter with zero flag, stops at zero     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module urna_pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/urna_ballot_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | urna_ballot_sender: frames a BCD ballot into Next/Digit/Valid for Urna    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module urna_ballot_sender
  import urna_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int VALID_CYCLES = 1,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic [URNA_DIGIT_W*DIGITS-1:0] BallotData,
  input  logic                           BallotValid,
  output logic                           BallotReady,
  input  logic                           CloseReq,
  output logic [URNA_DIGIT_W-1:0]        Digit,
  output logic                           Valid,
  output logic                           Next,
  output logic                           Finish,
  input  logic                           StatusValido,
  input  logic                           StatusNulo,
  output logic                           ResultStrobe,
  output logic                           ResultNulo,
  output logic                           Busy,
  output logic                           Closed
);

  localparam int BALLOT_W = URNA_DIGIT_W * DIGITS;
  localparam int CNT_W    = width_for(max3(SETUP_CYCLES, VALID_CYCLES, GAP_CYCLES));
  localparam int IDX_W    = width_for(DIGITS);

  localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_VALID_LD = CNT_W'(VALID_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

  state_t r_state, w_state_nxt;

  logic [BALLOT_W-1:0]     r_sr;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pend;
  logic [URNA_DIGIT_W-1:0] r_digit, w_digit;
  logic r_ready, r_valid, r_next, r_finish, r_strobe, r_nulo, r_busy, r_closed;
  logic w_ready, w_valid, w_next, w_finish, w_strobe, w_busy, w_closed;
  logic w_capture, w_shift, w_idx_clr, w_idx_inc, w_pend_set, w_pend_clr, w_nulo_cap;
  logic             w_tmr_load, w_tmr_zero;
  logic [CNT_W-1:0] w_tmr_val;
  logic [URNA_DIGIT_W-1:0] w_head;

  assign w_head = r_sr[BALLOT_W-1 -: URNA_DIGIT_W];

  urna_pulse_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // A close request during a ballot is remembered, never allowed to cut it short.
  assign w_pend_set = CloseReq && (r_state inside {S_NEXT, S_SETUP, S_STROBE, S_GAP, S_CHECK});

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = r_ready;
    w_busy      = r_busy;
    w_closed    = r_closed;
    w_digit     = r_digit;
    w_valid     = 1'b0;
    w_next      = 1'b0;
    w_finish    = 1'b0;
    w_strobe    = 1'b0;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_pend_clr  = 1'b0;
    w_nulo_cap  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      S_IDLE: begin
        if (r_pend || CloseReq) begin
          w_state_nxt = S_FINISH;
          w_finish    = 1'b1;
          w_ready     = 1'b0;
          w_busy      = 1'b1;
          w_pend_clr  = 1'b1;
        end else if (BallotValid && r_ready) begin
          w_state_nxt = S_NEXT;
          w_next      = 1'b1;
          w_ready     = 1'b0;
          w_busy      = 1'b1;
          w_capture   = 1'b1;
        end
      end
      S_NEXT: begin
        w_state_nxt = S_SETUP;
        w_digit     = w_head;
        w_shift     = 1'b1;
        w_idx_clr   = 1'b1;
        w_tmr_load  = 1'b1;
        w_tmr_val   = C_SETUP_LD;
      end
      S_SETUP: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_STROBE;
          w_valid     = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_VALID_LD;
        end
      end
      S_STROBE: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_GAP_LD;
        end else begin
          w_valid = 1'b1;
        end
      end
      S_GAP: begin
        if (w_tmr_zero) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = S_CHECK;
            w_strobe    = 1'b1;
            w_digit     = '0;
            w_nulo_cap  = 1'b1;
          end else begin
            w_state_nxt = S_SETUP;
            w_digit     = w_head;
            w_shift     = 1'b1;
            w_idx_inc   = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = C_SETUP_LD;
          end
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        w_busy      = 1'b0;
        w_ready     = !(r_pend || CloseReq);
      end
      S_FINISH: begin
        w_state_nxt = S_CLOSED;
        w_busy      = 1'b0;
        w_closed    = 1'b1;
        w_ready     = 1'b0;
      end
      S_CLOSED: begin
        w_state_nxt = S_CLOSED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sr     <= '0;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_digit  <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_next   <= 1'b0;
      r_finish <= 1'b0;
      r_strobe <= 1'b0;
      r_nulo   <= 1'b0;
      r_busy   <= 1'b0;
      r_closed <= 1'b0;
    end else begin
      r_digit  <= w_digit;
      r_ready  <= w_ready;
      r_valid  <= w_valid;
      r_next   <= w_next;
      r_finish <= w_finish;
      r_strobe <= w_strobe;
      r_busy   <= w_busy;
      r_closed <= w_closed;
      if (w_capture) begin
        r_sr <= BallotData;
      end else if (w_shift) begin
        r_sr <= r_sr << URNA_DIGIT_W;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_pend_clr) begin
        r_pend <= 1'b0;
      end else if (w_pend_set) begin
        r_pend <= 1'b1;
      end
      // A ballot Urna counted for a candidate is never reported as null.
      if (w_nulo_cap) begin
        r_nulo <= StatusNulo & ~StatusValido;
      end
    end
  end

  assign BallotReady  = r_ready;
  assign Digit        = r_digit;
  assign Valid        = r_valid;
  assign Next         = r_next;
  assign Finish       = r_finish;
  assign ResultStrobe = r_strobe;
  assign ResultNulo   = r_nulo;
  assign Busy         = r_busy;
  assign Closed       = r_closed;

endmodule
`default_nettype wire
